// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU request initiator
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 8;

  // Opcode encoding understood by the ALU; the initiator forwards it untouched.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_DONE,
    RESP
  } state_t;

  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] result;
    logic                      overflow;
    logic                      timeout;
  } alu_rsp_t;

endpackage

// File: rtl/alu_req_initiator_if.sv
// rtl/alu_req_initiator_if.sv - request, response and ALU bus signals of the initiator
interface alu_req_initiator_if #(
  parameter int DATA_WIDTH = alu_pkg::ALU_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_opcode;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_timeout;

  logic                  opcode_valid;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] data;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow;

  // Initiator side.
  modport master (
    input  req_valid, req_opcode, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
    input  rsp_ready,
    output opcode_valid, opcode, data,
    input  done, result, overflow
  );

  // Command source, response sink and ALU side.
  modport slave (
    output req_valid, req_opcode, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_timeout,
    output rsp_ready,
    input  opcode_valid, opcode, data,
    output done, result, overflow
  );

endinterface

// File: rtl/alu_req_initiator.sv
// rtl/alu_req_initiator.sv - serializes requests onto the ALU bus and returns responses; optional ALU_TIMEOUT_EN
module alu_req_initiator
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_req_initiator_if.master bus,
  output logic                busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state;
  state_t                state_nx;

  logic                  op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  ovf_q;
  logic                  tmo_q;
  logic                  cnt_term;

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_MIN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_MIN_W < 8) ? 8 : CNT_MIN_W;

  logic [CNT_W-1:0] wait_cnt;

  // The edge that would bring the count to TIMEOUT_CYCLES is the terminal one.
  assign cnt_term = (state == WAIT_DONE) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT_DONE cycles without done; held at zero outside WAIT_DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      wait_cnt <= '0;
    end else if (!bus.done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign cnt_term = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; done outside WAIT_DONE is deliberately ignored.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.req_valid) state_nx = SEND_A;
      SEND_A:    state_nx = SEND_B;
      SEND_B:    state_nx = WAIT_DONE;
      WAIT_DONE: if (bus.done || cnt_term) state_nx = RESP;
      RESP:      if (bus.rsp_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Latch the request in the accept cycle so the source may change it afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      op_q <= bus.req_opcode;
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
    end
  end

  // Capture the response; done takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else if (state == WAIT_DONE) begin
      if (bus.done) begin
        res_q <= bus.result;
        ovf_q <= bus.overflow;
        tmo_q <= 1'b0;
      end else if (cnt_term) begin
        res_q <= '0;
        ovf_q <= 1'b0;
        tmo_q <= 1'b1;
      end
    end
  end

  // Outputs decode directly from state so reset clears the ALU bus immediately.
  always_comb begin
    bus.req_ready    = reset_n && (state == IDLE);
    bus.opcode_valid = (state == SEND_A);
    bus.opcode       = (state == SEND_A) ? op_q : 1'b0;
    bus.data         = '0;
    if (state == SEND_A) bus.data = a_q;
    if (state == SEND_B) bus.data = b_q;
    bus.rsp_valid    = (state == RESP);
    bus.rsp_result   = res_q;
    bus.rsp_overflow = ovf_q;
    bus.rsp_timeout  = tmo_q;
    busy             = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_req_initiator.sv
// tb/tb_alu_req_initiator.sv - self-checking bench for alu_req_initiator
module tb_alu_req_initiator;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int TO = 8;

  typedef struct {
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            dly;    // WAIT_DONE cycles before done; -1 means never
    int            stall;  // cycles rsp_ready is held low
    logic [DW-1:0] res;
    logic          ov;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  int checks = 0;
  int errors = 0;

  alu_rsp_t sb[$];
  vec_t     vecs[7];

  alu_req_initiator_if #(.DATA_WIDTH(DW)) bus ();

  alu_req_initiator #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit spur_sendb);
    alu_rsp_t e;
    alu_rsp_t got_rsp;
    int       lat;
    int       exp_lat;
    bit       got;
    e.timeout  = (v.dly < 0);
    e.result   = e.timeout ? '0 : v.res;
    e.overflow = e.timeout ? 1'b0 : v.ov;
    exp_lat    = (v.dly < 0) ? TO : v.dly + 1;
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = v.op;
    bus.req_a      = v.a;
    bus.req_b      = v.b;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_opcode = 1'($urandom);
    bus.req_a      = DW'($urandom);
    bus.req_b      = DW'($urandom);
    chk("send_a_valid", bus.opcode_valid, 1);
    chk("send_a_opcode", bus.opcode, v.op);
    chk("send_a_data", bus.data, v.a);
    chk("send_a_busy", busy, 1);
    @(negedge clk);
    chk("send_b_valid", bus.opcode_valid, 0);
    chk("send_b_opcode", bus.opcode, 0);
    chk("send_b_data", bus.data, v.b);
    bus.done   = spur_sendb;
    bus.result = 8'h99;
    got = 1'b0;
    lat = -1;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = w;
      end else begin
        chk("wait_data", bus.data, 0);
        bus.done     = (w == v.dly);
        bus.result   = (w == v.dly) ? v.res : DW'($urandom);
        bus.overflow = (w == v.dly) ? v.ov : 1'($urandom);
      end
    end
    bus.done = 1'b0;
    chk("rsp_latency", lat, exp_lat);
    if (!got) begin
      void'(sb.pop_back());
      return;
    end
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_result", bus.rsp_result, e.result);
      chk("stall_overflow", bus.rsp_overflow, e.overflow);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.done      = e.timeout && (s == 0);
      bus.result    = 8'hFF;
      bus.overflow  = 1'b1;
      @(negedge clk);
    end
    bus.done      = 1'b0;
    bus.req_valid = 1'b0;
    chk("hs_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    got_rsp = sb.pop_front();
    chk("rsp_result", bus.rsp_result, got_rsp.result);
    chk("rsp_overflow", bus.rsp_overflow, got_rsp.overflow);
    chk("rsp_timeout", bus.rsp_timeout, got_rsp.timeout);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h12, 8'h34, 1, 0, 8'h46, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 0, 4, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'h05, 8'h03, 2, 1, 8'h02, 1'b0};
    vecs[3] = '{1'b1, 8'h03, 8'h05, 0, 0, 8'hFE, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 3, 2, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'hAA, 8'h55, 5, 0, 8'h55, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_opcode = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;
    bus.done       = 1'b0;
    bus.result     = '0;
    bus.overflow   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_opcode_valid", bus.opcode_valid, 0);
    chk("reset_data", bus.data, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    reset_n = 1'b1;
    #1;
    chk("release_req_ready", bus.req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

    bus.done   = 1'b1;
    bus.result = 8'h77;
    @(negedge clk);
    bus.done = 1'b0;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("spur_idle_rsp_valid2", bus.rsp_valid, 0);
    run_txn(vecs[0], 1'b1);
    repeat (2) @(negedge clk);
    chk("single_rsp_only", bus.rsp_valid, 0);

    bus.req_valid = 1'b1;
    bus.req_a     = 8'h05;
    bus.req_b     = 8'h03;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk("after_reset_rsp_valid", bus.rsp_valid, 0);

    bus.req_valid = 1'b1;
    bus.req_a     = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("send_a_pre_reset", bus.data, 8'h5A);
    reset_n = 1'b0;
    #1;
    chk("async_opcode_valid", bus.opcode_valid, 0);
    chk("async_data", bus.data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_txn('{1'b0, 8'h05, 8'h03, 0, 0, 8'h08, 1'b0}, 1'b0);

`ifdef ALU_TIMEOUT_EN
    run_txn('{1'b0, 8'h11, 8'h22, -1, 2, 8'h00, 1'b0}, 1'b0);
    run_txn('{1'b0, 8'h10, 8'h20, TO - 1, 0, 8'h30, 1'b0}, 1'b0);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_initiator.md
Name: alu_req_initiator

Overview:
Synthesizable initiator for the simple ALU operand protocol. It accepts complete operation requests (opcode plus two operands) on an upstream valid/ready port and serializes them onto the ALU bus (opcode_valid/opcode/data). It then waits for done and returns result/overflow on a downstream valid/ready port. It sits between a command source and the ALU, replacing the behavioural stimulus driver in system-level builds.

Parameters:
DATA_WIDTH, 8, width of operands, ALU data bus and result.
TIMEOUT_CYCLES, 64, WAIT_DONE cycles before a timeout response is produced (used only with ALU_TIMEOUT_EN).

Ports:
clk  in  1  single clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  upstream request valid
req_ready  out  1  initiator can accept a request
req_opcode  in  1  operation select, passed unmodified to ALU
req_a  in  DATA_WIDTH  first operand
req_b  in  DATA_WIDTH  second operand
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts response
rsp_result  out  DATA_WIDTH  captured ALU result
rsp_overflow  out  1  captured ALU overflow
rsp_timeout  out  1  response produced by timeout (0 when macro absent)
opcode_valid  out  1  ALU opcode strobe
opcode  out  1  ALU opcode
data  out  DATA_WIDTH  ALU operand bus
done  in  1  ALU completion strobe
result  in  DATA_WIDTH  ALU result, valid with done
overflow  in  1  ALU overflow, valid with done
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SEND_A, SEND_B, WAIT_DONE, RESP. Reset (asynchronous, reset_n=0) forces IDLE. All outputs are 0 during reset except req_ready, which is 1 once reset is released. Latched request and response registers are cleared.
- IDLE: req_ready=1. On req_valid&&req_ready at edge T, latch req_opcode/req_a/req_b and go to SEND_A.
- SEND_A (cycle T+1): opcode_valid=1, opcode=latched opcode, data=A. Go to SEND_B.
- SEND_B (cycle T+2): opcode_valid=0, data=B. Go to WAIT_DONE.
- WAIT_DONE: data=0, opcode_valid=0. On done=1, capture result and overflow, set rsp_timeout=0 and go to RESP. The earliest done is sampled at T+3, which makes the earliest rsp_valid T+4.
- RESP: rsp_valid=1. rsp_result, rsp_overflow and rsp_timeout stay stable until rsp_valid&&rsp_ready, then go to IDLE. req_ready is 0 here, so no request is accepted in the same cycle as the response handshake. Minimum request-to-request spacing is 5 cycles.
- opcode output is 0 in all states except SEND_A. data is 0 in IDLE, WAIT_DONE and RESP.
- done in IDLE, SEND_A, SEND_B or RESP is ignored with no state change.
- One transaction in flight only; no request queueing.
- Reset mid-transaction abandons it: no response is issued, and ALU outputs return to 0 immediately (asynchronously).
- Upstream request fields must be stable only in the accept cycle. Latched copies drive the ALU bus.

Optional Feature:
ALU_TIMEOUT_EN:
- With the macro: an 8-bit (or wider, sized by $clog2(TIMEOUT_CYCLES+1)) counter clears on entering WAIT_DONE and increments each WAIT_DONE cycle without done. When it reaches TIMEOUT_CYCLES, go to RESP with rsp_result=0, rsp_overflow=0, rsp_timeout=1. If done and the terminal count coincide, done wins and rsp_timeout=0. A late done after timeout is ignored.
- Without the macro: WAIT_DONE waits indefinitely, no counter is built, and rsp_timeout is tied 0.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_WIDTH default;
  - opcode encoding constants;
  - state enum typedef (IDLE, SEND_A, SEND_B, WAIT_DONE, RESP);
  - a response struct typedef {result, overflow, timeout}.
- No sub-module is required. The FSM, latches and optional counter are kept in one module; the counter is small enough to stay inline.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> opcode_valid=0, data=0, rsp_valid=0, busy=0. After release, req_ready=1.
- Single op: req opcode=0, A=8'h12, B=8'h34 accepted at T; ALU model asserts done at T+4 with result=8'h46, overflow=0 -> opcode_valid=1/data=8'h12 at T+1, data=8'h34 at T+2, rsp_valid at T+5 with rsp_result=8'h46.
- Overflow plus backpressure: A=8'hFF, B=8'h01, done with result=8'h00, overflow=1; hold rsp_ready=0 for 4 cycles -> response stays stable, req_ready=0 throughout, then IDLE one cycle after handshake.
- Spurious done: pulse done=1 in IDLE and in SEND_B -> no state change, no rsp_valid; the real done later produces exactly one response.
- Reset mid-op: assert reset_n=0 in WAIT_DONE, then release -> no rsp_valid, next request of A=8'h05, B=8'h03 completes normally.
- Timeout (ALU_TIMEOUT_EN, TIMEOUT_CYCLES=8): never assert done -> rsp_valid with rsp_timeout=1 and rsp_result=0 exactly 8 cycles after entering WAIT_DONE. A done on the terminal cycle gives rsp_timeout=0.
